// File: rtl/pc_mem_fetch.sv
// Instruction-fetch front end: a byte pc stepping one word per clock drives a
// word-addressed single-port memory.
module pc_mem_fetch #(
  parameter int    ADDRESS_WIDTH = 16,
  parameter int    DATA_WIDTH    = 32,
  parameter int    SIZE          = 6,
  parameter string INIT_FILE     = "program.hex"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [ADDRESS_WIDTH-1:0] pc_value,
  output logic [ADDRESS_WIDTH-1:0] pc_address,
  output logic [DATA_WIDTH-1:0]    data_out
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] SIZE_A  = ADDRESS_WIDTH'(SIZE);

  logic [ADDRESS_WIDTH-1:0] pc_p0;
  logic                     in_range;
  logic [IDX_W-1:0]         word_idx;

  // Storage powers up cleared.
  logic [DATA_WIDTH-1:0] mem [SIZE] = '{default: '0};

  // Stage p0: program counter, the only reset-controlled state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= '0;
    end else begin
      pc_p0 <= pc_p0 + PC_STEP;
    end
  end

  assign pc_value   = pc_p0;
  assign pc_address = pc_p0 >> 2;
  assign in_range   = (pc_address < SIZE_A);
  assign word_idx   = pc_address[IDX_W-1:0];

  // Read is combinational off the current pc; addresses past the array read as zero.
  assign data_out = in_range ? mem[word_idx] : '0;

  // Write lands at the pre-edge word; an edge seen under reset never writes.
  always_ff @(posedge clk) begin
    if (rst_n && write_enable && in_range) begin
      mem[word_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_pc_mem_fetch.sv
// Bench for pc_mem_fetch: table-driven write/readback vectors through a
// scoreboard queue, plus hand sequences for async reset and pc wrap-around.
module tb_pc_mem_fetch;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] pc_value;
  logic [AW-1:0] pc_address;
  logic [DW-1:0] data_out;

  pc_mem_fetch #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .SIZE         (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(write_enable),
    .data_in     (data_in),
    .pc_value    (pc_value),
    .pc_address  (pc_address),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [DW-1:0] din;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    string         name;
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t wr_tab[8];
  vec_t rd_tab[8];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push_exp(input string name, input logic [AW-1:0] pc, input logic [DW-1:0] data);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t          e;
    logic [AW-1:0] exp_addr;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got pc=%h data=%h, required a queued expectation", pc_value, data_out);
      return;
    end
    e = sb.pop_front();
    exp_addr = e.pc >> 2;
    if (pc_value !== e.pc || pc_address !== exp_addr || data_out !== e.data) begin
      n_errors++;
      $display("FAIL %s: got pc=%h addr=%h data=%h, required pc=%h addr=%h data=%h",
               e.name, pc_value, pc_address, data_out, e.pc, exp_addr, e.data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Write pass from reset: A000000k at words 0..5, then an ignored out-of-range write.
    for (int k = 0; k < 6; k++) begin
      wr_tab[k] = '{1'b1, 32'hA000_0000 + k, AW'(4 * (k + 1)), 32'h0};
    end
    wr_tab[6] = '{1'b1, 32'hDEAD_BEEF, 16'h001c, 32'h0};
    wr_tab[7] = '{1'b0, 32'h0,         16'h0020, 32'h0};
    // Readback pass after a reset pulse.
    for (int k = 0; k < 5; k++) begin
      rd_tab[k] = '{1'b0, 32'h0, AW'(4 * (k + 1)), 32'hA000_0001 + k};
    end
    rd_tab[5] = '{1'b0, 32'h0, 16'h0018, 32'h0};
    rd_tab[6] = '{1'b0, 32'h0, 16'h001c, 32'h0};
    rd_tab[7] = '{1'b0, 32'h0, 16'h0020, 32'h0};

    // Reset held for three edges
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push_exp("reset_hold", 16'h0000, 32'h0);
      check_pop();
      step();
    end
    rst_n = 1'b1;
    push_exp("post_release", 16'h0000, 32'h0);
    check_pop();

    for (int i = 0; i < 8; i++) begin
      write_enable = wr_tab[i].we;
      data_in      = wr_tab[i].din;
      push_exp($sformatf("write_pass[%0d]", i), wr_tab[i].exp_pc, wr_tab[i].exp_data);
      step();
      check_pop();
    end
    write_enable = 1'b0;

    // Reset pulse with a write attempted across a reset edge
    rst_n        = 1'b0;
    write_enable = 1'b1;
    data_in      = 32'h1234_5678;
    #1;
    push_exp("reset_async_a", 16'h0000, 32'hA000_0000);
    check_pop();
    step();
    push_exp("reset_edge_write", 16'h0000, 32'hA000_0000);
    check_pop();
    rst_n        = 1'b1;
    write_enable = 1'b0;
    push_exp("readback[0]", 16'h0000, 32'hA000_0000);
    check_pop();

    for (int i = 0; i < 8; i++) begin
      write_enable = rd_tab[i].we;
      data_in      = rd_tab[i].din;
      push_exp($sformatf("readback[%0d]", i + 1), rd_tab[i].exp_pc, rd_tab[i].exp_data);
      step();
      check_pop();
    end

    // Mid-cycle reset at pc 000c
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    step();
    @(posedge clk);
    #1;
    push_exp("pre_midreset", 16'h000c, 32'hA000_0003);
    check_pop();
    #1;
    rst_n        = 1'b0;
    write_enable = 1'b1;
    data_in      = 32'h5555_5555;
    #1;
    push_exp("midcycle_reset", 16'h0000, 32'hA000_0000);
    check_pop();
    @(negedge clk);
    step();
    rst_n        = 1'b1;
    write_enable = 1'b0;
    push_exp("after_midreset", 16'h0000, 32'hA000_0000);
    check_pop();
    for (int k = 1; k <= 5; k++) begin
      push_exp($sformatf("intact[%0d]", k), AW'(4 * k), 32'hA000_0000 + k);
      step();
      check_pop();
    end

    // Wrap-around: 16383 edges from reset reach fffc, one more returns to 0000
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (16383) @(posedge clk);
    @(negedge clk);
    push_exp("wrap_fffc", 16'hfffc, 32'h0);
    check_pop();
    push_exp("wrap_0000", 16'h0000, 32'hA000_0000);
    step();
    check_pop();
    push_exp("wrap_0004", 16'h0004, 32'hA000_0001);
    step();
    check_pop();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
